// File: rtl/flex_shift_pkg.sv
// Shared encodings for the flexible shift register: operation modes and burst FSM states.
package flex_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_HOLD6 = 3'b110,
        MODE_HOLD7 = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Only the four shift/rotate operations may be run as a multi-step burst.
    function automatic logic is_burst_mode(input logic [2:0] m);
        return mode_e'(m) inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR};
    endfunction

endpackage

// File: rtl/flex_shift_step.sv
// Combinational single step of the shift register: next value plus the bit pushed out.
module flex_shift_step
    import flex_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] nxt,
    output logic             out_bit,
    output logic             stepped
);

    always_comb begin
        nxt     = cur;
        out_bit = 1'b0;
        stepped = 1'b0;
        case (mode_e'(mode))
            MODE_LOAD: nxt = load_data;
            MODE_SHL: begin
                nxt     = {cur[WIDTH-2:0], serial_in};
                out_bit = cur[WIDTH-1];
                stepped = 1'b1;
            end
            MODE_SHR: begin
                nxt     = {serial_in, cur[WIDTH-1:1]};
                out_bit = cur[0];
                stepped = 1'b1;
            end
            MODE_ROL: begin
                nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
                out_bit = cur[WIDTH-1];
                stepped = 1'b1;
            end
            MODE_ROR: begin
                nxt     = {cur[0], cur[WIDTH-1:1]};
                out_bit = cur[0];
                stepped = 1'b1;
            end
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/flex_shift_reg.sv
// Loadable shift/rotate register with counted burst mode and synchronous set.
// Optional registered even-parity output when FLEX_SHIFT_PARITY_EN is defined.
module flex_shift_reg
    import flex_shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_count,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
`ifdef FLEX_SHIFT_PARITY_EN
    output logic             parity,
`endif
    output logic             fsm_state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       burst_mode_q, burst_mode_d;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q, q_d;
    logic             step_bit, step_active;
    logic             serial_out_d, done_d;

    flex_shift_step #(.WIDTH(WIDTH)) u_step (
        .cur       (q),
        .mode      (step_mode),
        .load_data (load_data),
        .serial_in (serial_in),
        .nxt       (step_q),
        .out_bit   (step_bit),
        .stepped   (step_active)
    );

    // Priority: set, then an active burst, then start, then the live mode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        burst_mode_d = burst_mode_q;
        done_d       = 1'b0;
        step_mode    = MODE_HOLD;
        q_d          = q;
        serial_out_d = serial_out;
        if (!set) begin
            q_d     = '1;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_BURST) begin
            step_mode = burst_mode_q;
            q_d       = step_q;
            if (step_active) serial_out_d = step_bit;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (start) begin
            if (is_burst_mode(mode) && shift_count != '0) begin
                state_d      = ST_BURST;
                cnt_d        = shift_count;
                burst_mode_d = mode;
            end else begin
                done_d = 1'b1;
            end
        end else begin
            step_mode = mode;
            q_d       = step_q;
            if (step_active) serial_out_d = step_bit;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            burst_mode_q <= MODE_HOLD;
            q            <= RESET_VAL;
            serial_out   <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            burst_mode_q <= burst_mode_d;
            q            <= q_d;
            serial_out   <= serial_out_d;
            done         <= done_d;
        end
    end

`ifdef FLEX_SHIFT_PARITY_EN
    // Computed from q_d so parity lands in the same cycle as the q it describes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) parity <= 1'b0;
        else        parity <= ^q_d;
    end
`endif

    assign busy      = (state_q == ST_BURST);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_flex_shift_reg.sv
// Directed, table-driven bench for flex_shift_reg (WIDTH=8, CNT_W=4, RESET_VAL=0).
module tb_flex_shift_reg;

    logic       clock = 1'b0;
    logic       reset;
    logic       set;
    logic [2:0] mode;
    logic [7:0] load_data;
    logic       serial_in;
    logic       start;
    logic [3:0] shift_count;
    logic [7:0] q;
    logic       serial_out;
    logic       busy;
    logic       done;
    logic       fsm_state;
`ifdef FLEX_SHIFT_PARITY_EN
    logic       parity;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [2:0] mode;
        logic [7:0] load_data;
        logic       serial_in;
        logic [7:0] exp_q;
        logic       exp_so;
    } vec_t;

    vec_t vecs[16];

    flex_shift_reg #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
        .clock       (clock),
        .reset       (reset),
        .set         (set),
        .mode        (mode),
        .load_data   (load_data),
        .serial_in   (serial_in),
        .start       (start),
        .shift_count (shift_count),
        .q           (q),
        .serial_out  (serial_out),
        .busy        (busy),
        .done        (done),
`ifdef FLEX_SHIFT_PARITY_EN
        .parity      (parity),
`endif
        .fsm_state   (fsm_state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [7:0] eq, input logic eb, input logic ed);
        chk({name, " q"}, 64'(q), 64'(eq));
        chk({name, " busy"}, 64'(busy), 64'(eb));
        chk({name, " done"}, 64'(done), 64'(ed));
    endtask

    int busy_n;
    int done_n;
    logic got_done;
    logic [7:0] eq;

    initial begin
        reset = 1'b0; set = 1'b1; mode = 3'b000; load_data = 8'h00;
        serial_in = 1'b0; start = 1'b0; shift_count = 4'd0;

        // Clock/reset block
        tick(); tick();
        chk_state("reset", 8'h00, 1'b0, 1'b0);
        chk("reset serial_out", 64'(serial_out), 64'd0);
        chk("reset fsm_state", 64'(fsm_state), 64'd0);
`ifdef FLEX_SHIFT_PARITY_EN
        chk("reset parity", 64'(parity), 64'd0);
`endif
        reset = 1'b1;

        // Asynchronous reset mid-cycle
        mode = 3'b001; load_data = 8'hA5;
        tick();
        chk("load A5", 64'(q), 64'hA5);
        mode = 3'b000;
        #2 reset = 1'b0;
        #1;
        chk_state("async reset", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b1;

        // Immediate-mode vector table, starting from q=00, serial_out=0
        vecs[0]  = '{3'b001, 8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1]  = '{3'b010, 8'h00, 1'b1, 8'h4B, 1'b1};
        vecs[2]  = '{3'b011, 8'h00, 1'b0, 8'h25, 1'b1};
        vecs[3]  = '{3'b100, 8'h00, 1'b0, 8'h4A, 1'b0};
        vecs[4]  = '{3'b101, 8'h00, 1'b1, 8'h25, 1'b0};
        vecs[5]  = '{3'b000, 8'hFF, 1'b1, 8'h25, 1'b0};
        vecs[6]  = '{3'b110, 8'hFF, 1'b1, 8'h25, 1'b0};
        vecs[7]  = '{3'b111, 8'hFF, 1'b1, 8'h25, 1'b0};
        vecs[8]  = '{3'b001, 8'h81, 1'b0, 8'h81, 1'b0};
        vecs[9]  = '{3'b100, 8'h00, 1'b0, 8'h03, 1'b1};
        vecs[10] = '{3'b011, 8'h00, 1'b1, 8'h81, 1'b1};
        vecs[11] = '{3'b010, 8'h00, 1'b0, 8'h02, 1'b1};
        vecs[12] = '{3'b101, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[13] = '{3'b101, 8'h00, 1'b0, 8'h80, 1'b1};
        vecs[14] = '{3'b001, 8'h07, 1'b0, 8'h07, 1'b1};
        vecs[15] = '{3'b001, 8'h03, 1'b0, 8'h03, 1'b1};

        foreach (vecs[i]) begin
            mode = vecs[i].mode; load_data = vecs[i].load_data; serial_in = vecs[i].serial_in;
            exp_q.push_back(vecs[i].exp_q);
            tick();
            eq = exp_q.pop_front();
            chk($sformatf("vec%0d q", i), 64'(q), 64'(eq));
            chk($sformatf("vec%0d serial_out", i), 64'(serial_out), 64'(vecs[i].exp_so));
`ifdef FLEX_SHIFT_PARITY_EN
            chk($sformatf("vec%0d parity", i), 64'(parity), 64'(^eq));
`endif
        end

        // Burst of 3 left shifts from 01; mode/load_data changes must be ignored
        mode = 3'b001; load_data = 8'h01;
        tick();
        mode = 3'b010; serial_in = 1'b0; shift_count = 4'd3; start = 1'b1;
        tick();
        chk_state("burst3 launch", 8'h01, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b001; load_data = 8'h55; shift_count = 4'hF;
        tick(); chk_state("burst3 step1", 8'h02, 1'b1, 1'b0);
        tick(); chk_state("burst3 step2", 8'h04, 1'b1, 1'b0);
        tick(); chk_state("burst3 step3", 8'h08, 1'b0, 1'b1);
        mode = 3'b000;
        tick(); chk_state("burst3 after", 8'h08, 1'b0, 1'b0);

        // Burst of 5 rotate-rights aborted by set after 2 steps
        mode = 3'b101; shift_count = 4'd5; start = 1'b1;
        tick();
        chk_state("abort launch", 8'h08, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick(); chk("abort step1 q", 64'(q), 64'h04);
        tick(); chk("abort step2 q", 64'(q), 64'h02);
        set = 1'b0;
        tick(); chk_state("abort set", 8'hFF, 1'b0, 1'b0);
        set = 1'b1;
        done_n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_n++;
        end
        chk("abort no done", 64'(done_n), 64'd0);
        chk("abort q held", 64'(q), 64'hFF);

        // Zero-count start and non-burst-mode start: done next cycle, no busy
        mode = 3'b010; shift_count = 4'd0; start = 1'b1;
        tick(); chk_state("zero start", 8'hFF, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick(); chk_state("zero after", 8'hFF, 1'b0, 1'b0);
        mode = 3'b001; load_data = 8'h00; shift_count = 4'd5; start = 1'b1;
        tick(); chk_state("load start", 8'hFF, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick();

        // Maximum count: 15 right shifts of FF with zero fill
        mode = 3'b011; serial_in = 1'b0; shift_count = 4'hF; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        busy_n = 0; got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            tick();
        end
        chk("max count busy cycles", 64'(busy_n), 64'd15);
        chk("max count done", 64'(got_done), 64'd1);
        chk("max count q", 64'(q), 64'h00);
        chk("max count serial_out", 64'(serial_out), 64'd0);

        // Set in idle overrides a load
        mode = 3'b001; load_data = 8'h0F; set = 1'b0;
        tick(); chk("set idle q", 64'(q), 64'hFF);
        set = 1'b1;
        tick(); chk("load 0F", 64'(q), 64'h0F);

        // Reset during a burst: no done afterwards
        mode = 3'b100; shift_count = 4'd4; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        tick(); chk("rst burst step1 q", 64'(q), 64'h1E);
        #2 reset = 1'b0;
        #1 chk_state("rst burst", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        done_n = 0; busy_n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_n++;
            if (busy) busy_n++;
        end
        chk("rst burst no done", 64'(done_n), 64'd0);
        chk("rst burst no busy", 64'(busy_n), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
